// File: rtl/sprite_fetch_arbiter_if.sv
// Bus bundle between the sprite renderers, the optional loader and the shared sprite RAM.
// The loader write signals exist only when SPRITE_ARB_WRITE_EN is defined.
interface sprite_fetch_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned ID_W    = 3
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic                      rd_valid;
  logic [ID_W-1:0]           rd_id;
  logic [DATA_W-1:0]         rd_data;
  logic                      rd_oob;
  logic [ADDR_W-1:0]         ram_read_address;
  logic [ADDR_W-1:0]         ram_write_address;
  logic                      ram_we;
  logic [DATA_W-1:0]         ram_data_in;
  logic [DATA_W-1:0]         ram_data_out;
`ifdef SPRITE_ARB_WRITE_EN
  logic                      wr_req;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic                      wr_ack;

  modport master (
    output req, req_addr, ram_data_out, wr_req, wr_addr, wr_data,
    input  gnt, rd_valid, rd_id, rd_data, rd_oob, wr_ack,
    input  ram_read_address, ram_write_address, ram_we, ram_data_in
  );
  modport slave (
    input  req, req_addr, ram_data_out, wr_req, wr_addr, wr_data,
    output gnt, rd_valid, rd_id, rd_data, rd_oob, wr_ack,
    output ram_read_address, ram_write_address, ram_we, ram_data_in
  );
`else
  modport master (
    output req, req_addr, ram_data_out,
    input  gnt, rd_valid, rd_id, rd_data, rd_oob,
    input  ram_read_address, ram_write_address, ram_we, ram_data_in
  );
  modport slave (
    input  req, req_addr, ram_data_out,
    output gnt, rd_valid, rd_id, rd_data, rd_oob,
    output ram_read_address, ram_write_address, ram_we, ram_data_in
  );
`endif
endinterface

// File: rtl/sprite_fetch_arbiter.sv
// Round-robin read arbiter for one synchronous-read sprite RAM, one access per cycle.
// Define SPRITE_ARB_WRITE_EN to add the loader write port with strict priority over reads.
module sprite_fetch_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DEPTH   = 2500,
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned ID_W    = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  sprite_fetch_arbiter_if.slave bus
);

  logic [ID_W-1:0]   r_ptr;
  logic              r_valid;
  logic [ID_W-1:0]   r_id;
  logic              r_oob;

  logic              w_wr_active;
  logic              w_any;
  logic [ID_W-1:0]   w_gnt_idx;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_oob;
  logic [ID_W-1:0]   w_ptr_next;
  int unsigned       w_best;
  int unsigned       w_dist;

`ifdef SPRITE_ARB_WRITE_EN
  assign w_wr_active           = bus.wr_req;
  assign bus.wr_ack            = bus.wr_req;
  // Out-of-range writes are still acked so the loader never stalls, but never reach the RAM.
  assign bus.ram_we            = bus.wr_req && (bus.wr_addr < ADDR_W'(DEPTH));
  assign bus.ram_write_address = bus.wr_req ? bus.wr_addr : '0;
  assign bus.ram_data_in       = bus.wr_req ? bus.wr_data : '0;
`else
  assign w_wr_active           = 1'b0;
  assign bus.ram_we            = 1'b0;
  assign bus.ram_write_address = '0;
  assign bus.ram_data_in       = '0;
`endif

  // Winner is the requester with the smallest modular distance from the pointer.
  always_comb begin
    w_best     = NUM_REQ;
    w_dist     = 0;
    w_gnt_idx  = '0;
    w_sel_addr = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_dist = (i + NUM_REQ - 32'(r_ptr)) % NUM_REQ;
      if (bus.req[i] && (w_dist < w_best)) begin
        w_best     = w_dist;
        w_gnt_idx  = ID_W'(i);
        w_sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
      end
    end
    w_any = (w_best != NUM_REQ) && !w_wr_active;
    w_oob = w_sel_addr >= ADDR_W'(DEPTH);
    if (!w_any) begin
      w_gnt_idx = '0;
      w_oob     = 1'b0;
    end
  end

  always_comb begin
    w_ptr_next = r_ptr;
    if (w_any) begin
      w_ptr_next = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  assign bus.gnt              = w_any ? (NUM_REQ'(1) << w_gnt_idx) : '0;
  assign bus.ram_read_address = (w_any && !w_oob) ? w_sel_addr : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_id    <= '0;
      r_oob   <= 1'b0;
    end else begin
      r_ptr   <= w_ptr_next;
      r_valid <= w_any;
      r_id    <= w_gnt_idx;
      r_oob   <= w_oob;
    end
  end

  assign bus.rd_valid = r_valid;
  assign bus.rd_id    = r_id;
  assign bus.rd_oob   = r_valid & r_oob;
  assign bus.rd_data  = (r_valid && !r_oob) ? bus.ram_data_out : '0;

endmodule

// File: doc/sprite_fetch_arbiter.md
# sprite_fetch_arbiter

Shares one synchronous-read sprite RAM (DEPTH words of DATA_W-bit colour, one-cycle registered read) between NUM_REQ sprite renderers and an optional loader write port. It issues at most one RAM access per cycle, grants reads in round-robin order, and returns each read word one cycle later tagged with the requester index. It sits between the per-object sprite renderers (invaders, player, bullets) and the sprite RAM instance they all draw from.

## Interface
- NUM_REQ, 4: number of read requesters, 2..8
- DEPTH, 2500: valid RAM words; addresses 0..DEPTH-1
- ADDR_W, 19: address width
- DATA_W, 24: colour word width
- ID_W, 3: requester index width, at least clog2(NUM_REQ)

- Clk  in  1  clock; all state on the rising edge
- Reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester read request
- req_addr  in  NUM_REQ*ADDR_W  flattened; requester i uses bits [i*ADDR_W +: ADDR_W]
- gnt  out  NUM_REQ  one-hot read grant, combinational, same cycle as the request
- rd_valid  out  1  read data valid
- rd_id  out  ID_W  requester index for rd_data
- rd_data  out  DATA_W  read word, 0 when rd_valid=0
- rd_oob  out  1  with rd_valid: the granted address was >= DEPTH
- wr_req, wr_addr, wr_data, wr_ack  in/in/in/out  1/ADDR_W/DATA_W/1  loader write port (present only with SPRITE_ARB_WRITE_EN)
- ram_read_address  out  ADDR_W  to RAM read port
- ram_write_address  out  ADDR_W  to RAM write port
- ram_we  out  1  RAM write enable
- ram_data_in  out  DATA_W  RAM write data
- ram_data_out  in  DATA_W  RAM registered read data

## Operation
- Requester protocol: hold req=1 with a stable address until gnt[i]=1 in the same cycle. Drop req, or present a new address, in the next cycle. At most one request per requester is in flight.
- Round-robin pointer ptr (0..NUM_REQ-1) sets the highest-priority index. The search order is ptr, ptr+1, … with modulo-NUM_REQ wrap. The first asserted req wins.
- After a grant to index g, ptr <= (g+1) mod NUM_REQ. With no grant, ptr holds.
- Granted address < DEPTH: ram_read_address = that address.
- Granted address >= DEPTH: ram_read_address = 0 and an oob flag is registered.
- With no grant, ram_read_address = 0.
- Response pipeline: registers valid_q, id_q and oob_q, loaded on every edge.
  - rd_valid = valid_q and rd_id = id_q.
  - rd_data = ram_data_out when valid_q=1 and oob_q=0. Otherwise rd_data = 0.
  - rd_oob = valid_q & oob_q.
- Write port (macro on):
  - wr_req has strict priority over all reads.
  - In a cycle with wr_req=1: wr_ack=1, ram_we=1, ram_write_address=wr_addr, ram_data_in=wr_data, gnt=0, and ptr holds.
  - A write with wr_addr >= DEPTH is acked but ram_we=0.
- Simultaneous events: write plus any reads means the write wins and the reads wait. Several reads means a single grant per cycle; the rest retry.
- Fairness: a requester holding req continuously is granted within NUM_REQ read-eligible cycles.

## Timing
- Reset values: ptr=0, valid_q=0, id_q=0, oob_q=0. Outputs: rd_valid=0, rd_id=0, rd_data=0, rd_oob=0, gnt=0 while req=0, ram_we=0, wr_ack=0.
- Latency: grant in cycle N, rd_valid in cycle N+1. Throughput is one read per cycle.
- gnt, wr_ack, ram_read_address, ram_write_address, ram_we and ram_data_in are combinational from the inputs and ptr. There are no registered request paths.
- Reset asserted mid-operation clears valid_q immediately (asynchronous), so any in-flight response is dropped. Requesters re-request after Reset deasserts.
- A grant presented in the same cycle that Reset deasserts is honoured normally.

## Configuration
- SPRITE_ARB_WRITE_EN
  - Defined: the wr_* ports exist and the write-priority behaviour applies.
  - Undefined: the wr_* ports are absent, and ram_we=0, ram_write_address=0, ram_data_in=0 constantly. The read arbitration is unchanged.

## Test plan
- Single requester: req[2]=1 with addr 37 and RAM word 37 = 24'hFF00FF → gnt=4'b0100 in cycle N; in N+1, rd_valid=1, rd_id=2, rd_data=24'hFF00FF, rd_oob=0.
- All four requesting continuously from reset → grants 0,1,2,3,0,… on consecutive cycles; rd_id follows one cycle later with no gaps.
- Wrap-around: ptr=3 with req=4'b0011 → grant index 0, then ptr=1.
- Out of range: req[1] with addr 2500 → gnt[1]=1 and ram_read_address=0; next cycle rd_valid=1, rd_oob=1, rd_data=0.
- Write priority (macro on): wr_req with addr 10, data 24'h123456, plus req=4'b1111 → wr_ack=1, gnt=0, ptr unchanged. Next cycle a read of addr 10 by requester 0 returns 24'h123456.
- Reset pulsed one cycle after a grant → rd_valid=0 immediately and ptr=0. After release, req[3] alone is granted and data returns normally.
